// File: rtl/vga_rd_sched_pkg.sv
// Shared types and 1280x800 defaults for the VGA frame-buffer read scheduler.
package vga_rd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT_SPACE,
    ST_REQ,
    ST_BURST
  } state_t;

  localparam int          WORD_CNT_W      = 18;
  localparam int          DEF_ADDR_W      = 28;
  localparam int          DEF_FIFO_AW     = 10;
  localparam int          DEF_BURST_LEN   = 64;
  localparam int          DEF_FRAME_WORDS = 128000;
  localparam logic [27:0] DEF_BUF0_BASE   = 28'h0000000;
  localparam logic [27:0] DEF_BUF1_BASE   = 28'h0200000;

  // Saturating event counter step.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_rd_sched_if.sv
// DDR burst-read request port between the scheduler (master) and the DDR read port (slave).
interface vga_rd_sched_if
  import vga_rd_sched_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              rd_ack;
  logic              rd_burst_done;

  modport master (
    output rd_req, rd_addr, rd_len,
    input  rd_ack, rd_burst_done
  );

  modport slave (
    input  rd_req, rd_addr, rd_len,
    output rd_ack, rd_burst_done
  );
endinterface

// File: rtl/vga_rd_addr_gen.sv
// Burst address and frame word counter: load at frame start, advance per completed burst.
module vga_rd_addr_gen
  import vga_rd_sched_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              vga_clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last_burst
);

  localparam logic [ADDR_W-1:0]     ADDR_STEP = ADDR_W'(BURST_LEN);
  localparam logic [WORD_CNT_W-1:0] CNT_STEP  = WORD_CNT_W'(BURST_LEN);
  localparam logic [WORD_CNT_W-1:0] LAST_CNT  = WORD_CNT_W'(FRAME_WORDS - BURST_LEN);

  logic [WORD_CNT_W-1:0] word_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      addr     <= '0;
      word_cnt <= '0;
    end else if (load) begin
      addr     <= base;
      word_cnt <= '0;
    end else if (advance) begin
      addr     <= addr + ADDR_STEP;   // wraps modulo 2^ADDR_W by design
      word_cnt <= word_cnt + CNT_STEP;
    end
  end

  // Frame-done flag: the burst now in flight is the last one of the frame.
  assign last_burst = (word_cnt == LAST_CNT);

endmodule

// File: rtl/vga_rd_sched.sv
// Frame-buffer read scheduler feeding the VGA display FIFO from ping-pong DDR buffers.
// Optional statistics outputs are enabled with `define VGA_RD_SCHED_STAT_EN.
module vga_rd_sched
  import vga_rd_sched_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                FIFO_AW     = DEF_FIFO_AW,
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [ADDR_W-1:0] BUF0_BASE   = DEF_BUF0_BASE,
  parameter logic [ADDR_W-1:0] BUF1_BASE   = DEF_BUF1_BASE
) (
  input  logic               vga_clk,
  input  logic               rstn,
  input  logic               frame_start,
  input  logic               wr_frame_done,
  input  logic               wr_buf_sel,
  input  logic [FIFO_AW:0]   fifo_wrusedw,
  output logic               fifo_clr,
  vga_rd_sched_if.master     ddr,
  output logic               rd_buf,
  output logic               busy
`ifdef VGA_RD_SCHED_STAT_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        overrun_cnt,
  output logic [15:0]        skip_cnt
`endif
);

  localparam int             FIFO_CW     = FIFO_AW + 1;
  localparam logic [FIFO_AW:0] FIFO_DEPTH  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] BURST_WORDS = FIFO_CW'(BURST_LEN);

  state_t            state, state_nxt;
  logic              ready_buf, ready_valid;
  logic              ovr_pend, settle;
  logic              sel_buf, sel_valid;
  logic              restart, space_ok;
  logic              load, advance, last_burst;
  logic [FIFO_AW:0]  fifo_free;
  logic [ADDR_W-1:0] addr;

  // A completion arriving with frame_start is already the newest buffer.
  assign sel_buf   = wr_frame_done ? wr_buf_sel : ready_buf;
  assign sel_valid = ready_valid | wr_frame_done;

  assign busy      = (state != ST_IDLE);
  assign restart   = busy & (frame_start | ovr_pend);
  assign fifo_free = FIFO_DEPTH - fifo_wrusedw;
  assign space_ok  = (fifo_free >= BURST_WORDS);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frame_start && sel_valid) begin
          state_nxt = ST_FLUSH;
          load      = 1'b1;
        end
      end
      ST_FLUSH: state_nxt = ST_WAIT_SPACE;
      ST_WAIT_SPACE: begin
        if (restart) begin
          state_nxt = ST_FLUSH;
          load      = 1'b1;
        end else if (!settle && space_ok) begin
          state_nxt = ST_REQ;
        end
      end
      // A pending overrun never withdraws an issued request.
      ST_REQ: begin
        if (ddr.rd_ack) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (ddr.rd_burst_done) begin
          advance = 1'b1;
          if (restart) begin
            state_nxt = ST_FLUSH;
            load      = 1'b1;
          end else if (last_burst) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_SPACE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      ready_buf   <= 1'b0;
      ready_valid <= 1'b0;
      rd_buf      <= 1'b0;
      ovr_pend    <= 1'b0;
      settle      <= 1'b0;
    end else begin
      state  <= state_nxt;
      settle <= (state == ST_FLUSH);   // skip one check while the flushed level settles
      if (wr_frame_done) begin
        ready_buf   <= wr_buf_sel;
        ready_valid <= 1'b1;
      end
      if (load) rd_buf <= sel_buf;
      if (load) ovr_pend <= 1'b0;
      else      ovr_pend <= ovr_pend | (busy & frame_start);
    end
  end

  vga_rd_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_addr_gen (
    .vga_clk    (vga_clk),
    .rstn       (rstn),
    .load       (load),
    .base       (sel_buf ? BUF1_BASE : BUF0_BASE),
    .advance    (advance),
    .addr       (addr),
    .last_burst (last_burst)
  );

  assign fifo_clr    = (state == ST_FLUSH);
  assign ddr.rd_req  = (state == ST_REQ);
  assign ddr.rd_addr = ddr.rd_req ? addr : '0;
  assign ddr.rd_len  = ddr.rd_req ? 8'(BURST_LEN) : 8'd0;

`ifdef VGA_RD_SCHED_STAT_EN
  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt   <= '0;
      overrun_cnt <= '0;
      skip_cnt    <= '0;
    end else begin
      if (state == ST_BURST && ddr.rd_burst_done && last_burst) frame_cnt <= sat_inc(frame_cnt);
      if (frame_start && busy) overrun_cnt <= sat_inc(overrun_cnt);
      if (frame_start && !busy && !sel_valid) skip_cnt <= sat_inc(skip_cnt);
    end
  end
`endif

endmodule

// File: doc/vga_rd_sched.md
Name: vga_rd_sched

Overview:
- Frame-buffer read scheduler in front of the VGA display FIFO; sequences DDR burst reads so the FIFO always holds the current frame ahead of the display scan.
- Selects the newest completed ping-pong buffer at each frame start, flushes the FIFO, then issues fixed-length bursts while FIFO space allows.
- Sits between the DDR read port and the write side of the display FIFO; same vga_clk domain as the display timing.

Parameters:
- ADDR_W, 28, DDR word address width
- FIFO_AW, 10, display FIFO address width; depth is 2^FIFO_AW words
- BURST_LEN, 64, words per DDR read burst, 1..255
- FRAME_WORDS, 128000, words per frame (1280x800 8-bit pixels, 64-bit words); integer multiple of BURST_LEN
- BUF0_BASE, 28'h0000000, word base address of buffer 0
- BUF1_BASE, 28'h0200000, word base address of buffer 1

Ports:
- vga_clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at display frame start (vsync falling edge)
- wr_frame_done  in  1  one-cycle pulse: writer completed buffer wr_buf_sel
- wr_buf_sel  in  1  buffer index the writer just completed
- fifo_wrusedw  in  FIFO_AW+1  display FIFO fill level in words
- fifo_clr  out  1  one-cycle FIFO flush pulse
- rd_req  out  1  burst read request, held until rd_ack
- rd_addr  out  ADDR_W  burst start word address, stable while rd_req is high
- rd_len  out  8  burst length, equal to BURST_LEN
- rd_ack  in  1  DDR port accepted the request
- rd_burst_done  in  1  last data word of the accepted burst written to the FIFO
- rd_buf  out  1  buffer currently being read
- busy  out  1  high while a frame is being fetched

Behaviour:
- Reset: every output is 0, the state is IDLE, and ready_valid is cleared.
- Buffer tracking: on wr_frame_done, ready_buf <= wr_buf_sel and ready_valid <= 1.
- IDLE:
  - On frame_start with ready_valid=1: latch rd_buf <= ready_buf, set word_cnt=0 and addr=base(rd_buf), go to FLUSH.
  - On frame_start with ready_valid=0: stay in IDLE; the FIFO stays empty and the display outputs black.
- FLUSH: assert fifo_clr for exactly 1 cycle and busy=1, then go to WAIT_SPACE.
- WAIT_SPACE:
  - If 2^FIFO_AW - fifo_wrusedw >= BURST_LEN, go to REQ.
  - The check is registered, so the earliest REQ is 1 cycle after the condition holds.
  - The first check comes 2 cycles after fifo_clr, which lets the flushed level propagate.
- REQ: rd_req=1 while rd_addr and rd_len are held. On rd_ack, drop rd_req the next cycle and go to BURST. An ack arriving in the same cycle rd_req first rises is valid.
- BURST: wait for rd_burst_done, then addr += BURST_LEN and word_cnt += BURST_LEN.
  - If word_cnt reaches FRAME_WORDS, go to IDLE and drop busy.
  - Otherwise go to WAIT_SPACE.
- Only one burst is outstanding at a time; there are no back-to-back requests without a space check.
- frame_start while busy=1 (frame overrun): abandon the fetch.
  - Any in-flight burst is still allowed to finish: in REQ keep waiting for rd_ack, in BURST wait for rd_burst_done.
  - Then re-enter FLUSH with the newest ready_buf. rd_req is never withdrawn before rd_ack.
- wr_frame_done in the same cycle as frame_start: the new wr_buf_sel wins and is latched as rd_buf.
- Arithmetic:
  - word_cnt is 18 bits unsigned; addr is ADDR_W bits and wraps modulo 2^ADDR_W with no error.
  - The space compare uses FIFO_AW+1 bits, so a full FIFO (fifo_wrusedw = 2^FIFO_AW) gives 0 space.
- Reset asserted mid-burst returns to IDLE immediately; the DDR port must be reset by the same rstn.

Optional Feature:
- Macro: VGA_RD_SCHED_STAT_EN.
- When defined, three extra outputs are added:
  - frame_cnt[15:0]: frames fully fetched.
  - overrun_cnt[15:0]: frame_start pulses that arrived while busy.
  - skip_cnt[15:0]: frame_start pulses that arrived in IDLE with ready_valid=0.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and their logic are absent and the rest of the behaviour is identical.

Decomposition:
- Package vga_rd_sched_pkg holds:
  - the state encoding (IDLE, FLUSH, WAIT_SPACE, REQ, BURST);
  - default buffer base addresses;
  - the FRAME_WORDS and BURST_LEN defaults for the 1280x800 mode.
- One sub-module, vga_rd_addr_gen: the address/word counter with load, advance, and frame-done flag.

Test Plan:
- No wr_frame_done, then frame_start → fifo_clr and rd_req stay 0, busy=0, skip_cnt=1 (with macro).
- wr_frame_done with wr_buf_sel=1, then frame_start, fifo_wrusedw=0, rd_ack 1 cycle after each request, rd_burst_done 70 cycles later:
  - fifo_clr pulses once;
  - first rd_addr=28'h0200000, then +64 per burst;
  - exactly 2000 requests, then busy=0 and frame_cnt=1.
- fifo_wrusedw held at 961 (free 63):
  - no rd_req issued;
  - dropping it to 960 gives rd_req within 2 cycles.
- frame_start during BURST of burst #10:
  - no new rd_req until rd_burst_done;
  - then fifo_clr, and rd_addr restarts at the newest buffer base;
  - overrun_cnt=1.
- wr_frame_done (wr_buf_sel=0) in the same cycle as frame_start → rd_buf=0 and first rd_addr=28'h0000000.
- rstn pulsed low while rd_req=1 → all outputs 0 asynchronously; after release the block stays in IDLE until the next frame_start.
